cfg_rsp_engine: RTL and testbench

Far-end responder for the configuration-access protocol carried over the serial link. It accepts decoded write/read requests from the link receive path and executes each one on the local register bus, with an ack timeout. It then returns exactly one response per request to the link transmit path. It sits between the RX frame decoder and the TX frame encoder inside the top level. Type 0 requests target the 16-bit PHY/management space; type 1 requests target the 32-bit local register space.

---
 rtl/cfg_link_pkg.sv | 29 ++
 rtl/cfg_rsp_engine.sv | 183 ++++++++++++++++++
 tb/tb_cfg_rsp_engine.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_link_pkg.sv
// Shared definitions for the configuration-access link: request space types,
// response status codes, the responder FSM state type and a data-mask helper.
// Used by the RX decoder, the TX encoder and cfg_rsp_engine.
package cfg_link_pkg;

    // Request space selector
    localparam logic CFG_TYPE_16 = 1'b0;  // 16-bit PHY/management space
    localparam logic CFG_TYPE_32 = 1'b1;  // 32-bit local register space

    // Response status codes
    localparam logic [1:0] CFG_ST_OK       = 2'd0;
    localparam logic [1:0] CFG_ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] CFG_ST_BAD_ADDR = 2'd2;

    // Responder FSM states
    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } cfg_rsp_state_e;

    // The 16-bit space only carries the low half of the data word.
    function automatic logic [31:0] cfg_mask_data(input logic       req_type,
                                                  input logic [31:0] data);
        return (req_type == CFG_TYPE_16) ? {16'h0000, data[15:0]} : data;
    endfunction

endpackage

// File: rtl/cfg_rsp_engine.sv
// cfg_rsp_engine: far-end responder for configuration-access requests.
// Accepts one decoded write/read request at a time, executes it on the local
// register bus with an ack timeout and returns exactly one response.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_*               request from the RX decoder (valid/ready handshake)
//   bus_*               local register bus: one-cycle strobes, registered
//                       type/address/write data, read data qualified by ack
//   rsp_*               response to the TX encoder (valid/ready handshake)
//   err_cnt             saturating count of TIMEOUT/BAD_ADDR responses
module cfg_rsp_engine
    import cfg_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,  // 2..65535
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_type,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,

    output logic              bus_wr_en,
    output logic              bus_rd_en,
    output logic              bus_type,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wr_data,
    input  logic [31:0]       bus_rd_data,
    input  logic              bus_ack,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_type,
    output logic              rsp_wr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_status,

    output logic [15:0]       err_cnt
);

    // Counter value in the last WAIT cycle before a timeout is declared.
    localparam logic [15:0] CntLast = 16'(TIMEOUT_CYC - 1);

    cfg_rsp_state_e    state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              type_q, type_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        err_cnt_d    = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    type_d = req_type;
                    wr_d   = req_wr;
                    addr_d = req_addr;
                    data_d = cfg_mask_data(req_type, req_data);
                    cnt_d  = '0;
                    if (req_type == CFG_TYPE_32 && req_addr[1:0] != 2'b00) begin
                        // Misaligned 32-bit access: answer directly, never touch the bus.
                        state_d      = StResp;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = CFG_ST_BAD_ADDR;
                        rsp_data_d   = '0;
                    end else begin
                        // Strobes are registered so they appear in the ACCESS cycle.
                        state_d = StAccess;
                        wr_en_d = req_wr;
                        rd_en_d = !req_wr;
                    end
                end
            end

            // Counter is 0 in ACCESS and CntLast >= 1, so ACCESS never times out.
            StAccess, StWait: begin
                if (bus_ack) begin
                    state_d      = StResp;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = CFG_ST_OK;
                    rsp_data_d   = wr_q ? data_q : cfg_mask_data(type_q, bus_rd_data);
                end else if (cnt_q == CntLast) begin
                    state_d      = StResp;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = CFG_ST_TIMEOUT;
                    rsp_data_d   = '0;
                end else begin
                    state_d = StWait;
                    cnt_d   = cnt_q + 16'd1;
                end
            end

            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    if (rsp_status_q != CFG_ST_OK && err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        req_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b0;
            type_q       <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= CFG_ST_OK;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            type_q       <= type_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // The latched request doubles as bus command and response echo; it only
    // changes on accept, so it is stable through ACCESS, WAIT and RESP.
    assign req_ready   = req_ready_q;
    assign bus_wr_en   = wr_en_q;
    assign bus_rd_en   = rd_en_q;
    assign bus_type    = type_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_type    = type_q;
    assign rsp_wr      = wr_q;
    assign rsp_addr    = addr_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_cfg_rsp_engine.sv
// Self-checking bench for cfg_rsp_engine: directed cases followed by
// randomized transactions checked against a cycle-count/arithmetic model.
module tb_cfg_rsp_engine;

    localparam int unsigned T  = 16;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_type = 1'b0;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_data = '0;
    logic          bus_wr_en, bus_rd_en, bus_type;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wr_data;
    logic [31:0]   bus_rd_data = '0;
    logic          bus_ack = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_type, rsp_wr;
    logic [AW-1:0] rsp_addr;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_status;
    logic [15:0]   err_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned mdl_err  = 0;

    always #5 clk = ~clk;

    cfg_rsp_engine #(
        .TIMEOUT_CYC (T),
        .ADDR_W      (AW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_type    (req_type),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .bus_wr_en   (bus_wr_en),
        .bus_rd_en   (bus_rd_en),
        .bus_type    (bus_type),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_ack     (bus_ack),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_type    (rsp_type),
        .rsp_wr      (rsp_wr),
        .rsp_addr    (rsp_addr),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .err_cnt     (err_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag, input logic exp_ready);
        check_val({tag, "_req_ready"}, 32'(req_ready), 32'(exp_ready));
        check_val({tag, "_bus_strobes"}, 32'({bus_wr_en, bus_rd_en}), 32'd0);
        check_val({tag, "_bus_type"}, 32'(bus_type), 32'd0);
        check_val({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
        check_val({tag, "_bus_wr_data"}, bus_wr_data, 32'd0);
        check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_val({tag, "_rsp_echo"}, 32'({rsp_type, rsp_wr, rsp_addr}), 32'd0);
        check_val({tag, "_rsp_data"}, rsp_data, 32'd0);
        check_val({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
        check_val({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // One complete transaction. Called #1 after a clock edge with the DUT idle.
    // ack_k: ack k cycles after the strobe cycle (<0: never). late_ack: extra
    // ack at that cycle number (0: none). hold: cycles rsp_ready stays low.
    task automatic run_txn(input logic t, input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input int ack_k, input logic [31:0] rdd,
                           input int hold, input int late_ack);
        logic        bad;
        int          exp_lat;
        logic [1:0]  exp_st;
        logic [31:0] exp_d;
        logic [31:0] exp_wd;
        int          c, rsp_cyc, strobes, strobe_cyc;
        bit          done;

        // Reference model: outcome and latency from the protocol rules.
        exp_wd = t ? wd : (wd & 32'h0000_FFFF);
        bad    = t && (addr % 4 != 0);
        if (bad) begin
            exp_lat = 1; exp_st = 2'd2; exp_d = 0;
        end else if (ack_k >= 0 && ack_k + 1 <= int'(T)) begin
            exp_lat = 2 + ack_k; exp_st = 2'd0; exp_d = wr ? wd : rdd;
        end else begin
            exp_lat = 1 + int'(T); exp_st = 2'd1; exp_d = 0;
        end
        if (!t) exp_d = exp_d & 32'h0000_FFFF;

        check_val("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_type  = t;
        req_wr    = wr;
        req_addr  = addr;
        req_data  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_type  = 1'($urandom);
        req_wr    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_data  = $urandom;

        c = 1; rsp_cyc = 0; strobes = 0; strobe_cyc = 0; done = 0;
        while (!done && c < int'(T) + hold + 30) begin
            if (bus_wr_en || bus_rd_en) begin
                strobes++;
                strobe_cyc = c;
                check_val("bus_wr_en", 32'(bus_wr_en), 32'(wr));
                check_val("bus_rd_en", 32'(bus_rd_en), 32'(!wr));
                check_val("bus_type", 32'(bus_type), 32'(t));
                check_val("bus_addr", 32'(bus_addr), 32'(addr));
                if (wr) check_val("bus_wr_data", bus_wr_data, exp_wd);
            end
            if (rsp_valid) begin
                if (rsp_cyc == 0) rsp_cyc = c;
                check_val("rsp_type", 32'(rsp_type), 32'(t));
                check_val("rsp_wr", 32'(rsp_wr), 32'(wr));
                check_val("rsp_addr", 32'(rsp_addr), 32'(addr));
                check_val("rsp_data", rsp_data, exp_d);
                check_val("rsp_status", 32'(rsp_status), 32'(exp_st));
                check_val("req_ready_busy", 32'(req_ready), 32'd0);
                if (c - rsp_cyc >= hold) begin
                    rsp_ready = 1'b1;
                    done = 1;
                end
            end
            bus_ack     = (ack_k >= 0 && c == 1 + ack_k) || (c == late_ack);
            bus_rd_data = bus_ack ? rdd : $urandom;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            bus_ack   = 1'b0;
            c++;
        end

        check_val("rsp_seen", 32'(done), 32'd1);
        check_val("rsp_latency", 32'(rsp_cyc), 32'(exp_lat));
        check_val("strobe_count", 32'(strobes), bad ? 32'd0 : 32'd1);
        check_val("strobe_cycle", 32'(strobe_cyc), bad ? 32'd0 : 32'd1);
        if (done && exp_st != 2'd0 && mdl_err < 65535) mdl_err++;
        check_val("err_cnt", 32'(err_cnt), mdl_err);
        check_val("rsp_valid_after", 32'(rsp_valid), 32'd0);
        check_val("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int          n_rsp;
        logic        t, wr;
        logic [AW-1:0] a;
        int          k;

        #2;
        check_all_zero("reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_txn(1'b0, 1'b1, 16'hFFFF, 32'h0000_AB4A, 3, 32'h0, 0, 0);
        run_txn(1'b0, 1'b0, 16'hFFFF, 32'h0, 2, 32'h1234_AB4A, 0, 0);
        run_txn(1'b1, 1'b1, 16'h041C, 32'hABCD_0000, 0, 32'h0, 0, 0);
        run_txn(1'b1, 1'b0, 16'h041C, 32'h0, 0, 32'hABCD_0000, 0, 0);
        run_txn(1'b1, 1'b0, 16'h041E, 32'h0, 0, 32'hDEAD_BEEF, 0, 0);
        // Timeout, with a late ack arriving while the response is held
        run_txn(1'b1, 1'b0, 16'h0100, 32'h0, -1, 32'h5A5A_5A5A, 6, 21);
        run_txn(1'b1, 1'b0, 16'h0104, 32'h0, 1, 32'h1357_9BDF, 0, 0);
        // Ack in the last possible cycle beats the timeout
        run_txn(1'b0, 1'b0, 16'h0200, 32'h0, int'(T) - 1, 32'hFFFF_8001, 0, 0);
        // Response back-pressure
        run_txn(1'b1, 1'b1, 16'h0040, 32'hCAFE_F00D, 1, 32'h0, 10, 0);

        // Reset while waiting for ack
        req_valid = 1'b1; req_type = 1'b1; req_wr = 1'b0;
        req_addr = 16'h0308; req_data = 32'h1111_2222;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("wait_no_rsp", 32'(rsp_valid), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset", 1'b0);
        mdl_err = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("ready_after_reset", 32'(req_ready), 32'd1);
        n_rsp = 0;
        for (int i = 0; i < 20; i++) begin
            bus_ack = (i == 3);
            if (rsp_valid || bus_wr_en || bus_rd_en) n_rsp++;
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        check_val("no_rsp_after_reset", 32'(n_rsp), 32'd0);

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            t  = 1'($urandom);
            wr = 1'($urandom);
            a  = AW'($urandom);
            if (t && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            k  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T + 3));
            run_txn(t, wr, a, $urandom, k, $urandom, int'($urandom_range(0, 3)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
